// File: rtl/if_stage_if.sv
// IF-stage bus: hazard/redirect inputs, instruction ROM port and IF/ID register outputs.
// IF_PERF_CNT_EN adds the fetch/stall/flush counter outputs.
interface if_stage_if;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_adr;
   logic [31:0] imem_adrs;
   logic [31:0] imem_inst;
   logic [31:0] pc_out;
   logic [31:0] inst_out;
   logic        valid_out;
   logic        fault;
`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   modport master (
      input  freeze, branch_taken, branch_adr, imem_inst,
      output imem_adrs, pc_out, inst_out, valid_out, fault,
      output fetch_cnt, stall_cnt, flush_cnt
   );
   modport slave (
      output freeze, branch_taken, branch_adr, imem_inst,
      input  imem_adrs, pc_out, inst_out, valid_out, fault,
      input  fetch_cnt, stall_cnt, flush_cnt
   );
`else
   modport master (
      input  freeze, branch_taken, branch_adr, imem_inst,
      output imem_adrs, pc_out, inst_out, valid_out, fault
   );
   modport slave (
      output freeze, branch_taken, branch_adr, imem_inst,
      input  imem_adrs, pc_out, inst_out, valid_out, fault
   );
`endif
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, ROM address drive, IF/ID register, freeze/redirect/fault handling.
// Optional performance counters are compiled in with IF_PERF_CNT_EN.
module if_stage #(
   parameter logic [31:0] RESET_PC   = 32'd0,
   parameter logic [31:0] PC_STEP    = 32'd4,
   parameter logic [31:0] ADDR_LIMIT = 32'd1000
) (
   input logic       clk,
   input logic       rst,
   if_stage_if.master bus
);

   typedef enum logic [1:0] {RUN, STALL, FAULT} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] seq_pc;
   logic [31:0] next_cand;
   logic        fault_now;
   logic [31:0] pc_q;
   logic [31:0] inst_q;
   logic        valid_q;
   logic        fault_q;
`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_q;
   logic [31:0] stall_q;
   logic [31:0] flush_q;
`endif

   // The fault check looks at the PC this edge would load: redirect target,
   // held PC on freeze, or the sequential successor.
   always_comb begin
      seq_pc    = pc + PC_STEP;
      next_cand = seq_pc;
      if (bus.branch_taken)
         next_cand = bus.branch_adr;
      else if (bus.freeze)
         next_cand = pc;
      fault_now = (next_cand[1:0] != 2'b00) || (next_cand >= ADDR_LIMIT) ||
                  (pc >= ADDR_LIMIT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= RUN;
         pc      <= RESET_PC;
         pc_q    <= '0;
         inst_q  <= '0;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
`ifdef IF_PERF_CNT_EN
         fetch_q <= '0;
         stall_q <= '0;
         flush_q <= '0;
`endif
      end else if (state != FAULT) begin
         if (fault_now) begin
            state   <= FAULT;
            fault_q <= 1'b1;
            pc_q    <= '0;
            inst_q  <= '0;
            valid_q <= 1'b0;
         end else if (bus.branch_taken) begin
            state   <= RUN;
            pc      <= bus.branch_adr;
            pc_q    <= '0;
            inst_q  <= '0;
            valid_q <= 1'b0;
`ifdef IF_PERF_CNT_EN
            flush_q <= flush_q + 32'd1;
`endif
         end else if (bus.freeze) begin
            state <= STALL;
`ifdef IF_PERF_CNT_EN
            stall_q <= stall_q + 32'd1;
`endif
         end else begin
            state   <= RUN;
            pc      <= seq_pc;
            pc_q    <= seq_pc;
            inst_q  <= bus.imem_inst;
            valid_q <= 1'b1;
`ifdef IF_PERF_CNT_EN
            fetch_q <= fetch_q + 32'd1;
`endif
         end
      end
   end

   assign bus.imem_adrs = pc;
   assign bus.pc_out    = pc_q;
   assign bus.inst_out  = inst_q;
   assign bus.valid_out = valid_q;
   assign bus.fault     = fault_q;
`ifdef IF_PERF_CNT_EN
   assign bus.fetch_cnt = fetch_q;
   assign bus.stall_cnt = stall_q;
   assign bus.flush_cnt = flush_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: vector table for the main fetch/stall/branch/fault flow,
// plus hand sequences for mid-stall reset and misaligned redirect.
module tb_if_stage;

   logic clk;
   logic rst;
   int unsigned checks;
   int unsigned errors;

   if_stage_if bus ();

   if_stage #(.RESET_PC(32'd0), .PC_STEP(32'd4), .ADDR_LIMIT(32'd1000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [31:0] rom(input logic [31:0] a);
      if (a == 32'd0) return 32'h0;
      if (a == 32'd4) return 32'h8001060A;
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
   endfunction

   assign bus.imem_inst = rom(bus.imem_adrs);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        freeze;
      logic        branch;
      logic [31:0] badr;
      logic [31:0] e_adrs;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      logic        e_valid;
      logic        e_fault;
   } vec_t;

   vec_t vecs [18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic [31:0] adrs, input logic [31:0] pcv,
                           input logic [31:0] inst, input logic valid, input logic flt);
      chk({tag, ".imem_adrs"}, bus.imem_adrs, adrs);
      chk({tag, ".pc_out"},    bus.pc_out,    pcv);
      chk({tag, ".inst_out"},  bus.inst_out,  inst);
      chk({tag, ".valid_out"}, {31'd0, bus.valid_out}, {31'd0, valid});
      chk({tag, ".fault"},     {31'd0, bus.fault},     {31'd0, flt});
   endtask

   task automatic step(input logic frz, input logic br, input logic [31:0] badr);
      bus.freeze       = frz;
      bus.branch_taken = br;
      bus.branch_adr   = badr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      // {freeze, branch, badr, imem_adrs, pc_out, inst_out, valid, fault} after each edge
      vecs[0]  = '{0, 0, 0,    4,   4,   rom(0),   1, 0};
      vecs[1]  = '{0, 0, 0,    8,   8,   rom(4),   1, 0};
      vecs[2]  = '{0, 0, 0,    12,  12,  rom(8),   1, 0};
      vecs[3]  = '{0, 0, 0,    16,  16,  rom(12),  1, 0};
      vecs[4]  = '{1, 0, 0,    16,  16,  rom(12),  1, 0};
      vecs[5]  = '{1, 0, 0,    16,  16,  rom(12),  1, 0};
      vecs[6]  = '{1, 0, 0,    16,  16,  rom(12),  1, 0};
      vecs[7]  = '{0, 0, 0,    20,  20,  rom(16),  1, 0};
      vecs[8]  = '{0, 1, 320,  320, 0,   0,        0, 0};
      vecs[9]  = '{0, 1, 208,  208, 0,   0,        0, 0};
      vecs[10] = '{0, 0, 0,    212, 212, rom(208), 1, 0};
      vecs[11] = '{1, 1, 100,  100, 0,   0,        0, 0};
      vecs[12] = '{0, 0, 0,    104, 104, rom(100), 1, 0};
      vecs[13] = '{0, 1, 992,  992, 0,   0,        0, 0};
      vecs[14] = '{0, 0, 0,    996, 996, rom(992), 1, 0};
      vecs[15] = '{0, 0, 0,    996, 0,   0,        0, 1};
      vecs[16] = '{0, 1, 0,    996, 0,   0,        0, 1};
      vecs[17] = '{1, 0, 0,    996, 0,   0,        0, 1};

      bus.freeze = 1'b0;
      bus.branch_taken = 1'b0;
      bus.branch_adr = '0;
      rst = 1'b0;
      #12;
      chk_outs("reset", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 18; i++) begin
         step(vecs[i].freeze, vecs[i].branch, vecs[i].badr);
         chk_outs($sformatf("vec%0d", i), vecs[i].e_adrs, vecs[i].e_pc,
                  vecs[i].e_inst, vecs[i].e_valid, vecs[i].e_fault);
      end
`ifdef IF_PERF_CNT_EN
      chk("fetch_cnt", bus.fetch_cnt, 32'd8);
      chk("stall_cnt", bus.stall_cnt, 32'd3);
      chk("flush_cnt", bus.flush_cnt, 32'd4);
`endif

      // Asynchronous reset taken in the middle of a stall.
      @(negedge clk);
      rst = 1'b0;
      #1;
      rst = 1'b1;
      step(0, 0, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      chk_outs("stall_pre", 32'd4, 32'd4, rom(0), 1'b1, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      chk_outs("async_rst", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
`ifdef IF_PERF_CNT_EN
      chk("rst_stall_cnt", bus.stall_cnt, 32'd0);
`endif
      @(negedge clk);
      rst = 1'b1;
      step(0, 0, 0);
      chk_outs("restart", 32'd4, 32'd4, rom(0), 1'b1, 1'b0);

      // Misaligned redirect faults and later branches are ignored.
      step(0, 1, 102);
      chk_outs("misalign", 32'd4, 32'd0, 32'd0, 1'b0, 1'b1);
      step(0, 1, 8);
      chk_outs("ignore_br", 32'd4, 32'd0, 32'd0, 1'b0, 1'b1);
      step(0, 0, 0);
      chk_outs("fault_hold", 32'd4, 32'd0, 32'd0, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
